// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Funct3 encodings, FSM states and access-size helpers used by mem_lsu and lsu_load_align.
package mem_lsu_pkg;

  typedef logic        enable_t;
  typedef logic [31:0] data_t;

  localparam int WSTRB_W = 4;

  // Store encodings share values with the loads, so they are aliases of the same enum.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_funct3_t;

  localparam mem_funct3_t SB = LB;
  localparam mem_funct3_t SH = LH;
  localparam mem_funct3_t SW = LW;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  function automatic logic is_half(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

  function automatic logic is_word(input logic [2:0] funct3);
    return funct3[1];
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    return (is_half(funct3) && offset[0]) || (is_word(funct3) && (offset != 2'b00));
  endfunction

  // Drops the low address bits that a halfword or word access cannot honour.
  function automatic logic [1:0] clear_offset(input logic [2:0] funct3, input logic [1:0] offset);
    logic [1:0] res;
    res = offset;
    if (is_half(funct3)) res[0] = 1'b0;
    if (is_word(funct3)) res = 2'b00;
    return res;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result formatting: picks the byte/halfword lane from the read word and
// sign- or zero-extends it according to funct3.
module lsu_load_align
  import mem_lsu_pkg::*;
(
  input  data_t       rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output data_t       result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LBU:     result = {24'd0, byte_sel};
      LHU:     result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one word-wide bus access per memory instruction,
// stalling the pipeline until it completes. Optional macro LSU_MISALIGN_TRAP_EN
// turns misaligned halfword/word accesses into a trap instead of clearing the low bits.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  enable_t            mem_req_c_i,
  input  enable_t            mem_write_c_i,
  input  logic [2:0]         mem_funct3_i,
  input  data_t              addr_i,
  input  data_t              store_data_i,
  output data_t              load_data_o,
  output enable_t            stall_c_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output data_t              bus_addr_o,
  output data_t              bus_wdata_o,
  output logic [WSTRB_W-1:0] bus_wstrb_o,
  input  logic               bus_gnt_i,
  input  logic               bus_rvalid_i,
  input  data_t              bus_rdata_i
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic               misalign_o
`endif
);

  lsu_state_t         state_q, state_d;
  data_t              addr_q, wdata_q, load_data_q, load_fmt;
  logic [WSTRB_W-1:0] wstrb_q, wstrb_fmt;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [1:0]         offset_q, offset_eff;
  data_t              wdata_fmt;
  logic               trap;
  logic               accept;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  assign trap       = mem_req_c_i && is_misaligned(mem_funct3_i, addr_i[1:0]);
  assign misalign_o = misalign_q;
`else
  assign trap = 1'b0;
`endif

  assign accept = (state_q == IDLE) && mem_req_c_i;

  // Store lane formatting from the live EX2MEM inputs; captured on accept.
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    offset_eff = clear_offset(mem_funct3_i, addr_i[1:0]);
    wstrb_fmt  = '0;
    wdata_fmt  = store_data_i;
    if (is_word(mem_funct3_i)) begin
      wstrb_fmt = 4'b1111;
    end else if (is_half(mem_funct3_i)) begin
      wstrb_fmt = 4'b0011 << {offset_eff[1], 1'b0};
      wdata_fmt = {2{store_data_i[15:0]}};
    end else begin
      wstrb_fmt = 4'b0001 << offset_eff;
      wdata_fmt = {4{store_data_i[7:0]}};
    end
    if (!mem_write_c_i) wstrb_fmt = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_req_c_i) state_d = trap ? DONE : REQ;
      REQ:     if (bus_gnt_i) state_d = we_q ? DONE : WAIT;
      WAIT:    if (bus_rvalid_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata  (bus_rdata_i),
    .funct3 (funct3_q),
    .offset (offset_q),
    .result (load_fmt)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      offset_q    <= '0;
      load_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept && !trap) begin
        addr_q   <= {addr_i[31:2], 2'b00};
        wdata_q  <= wdata_fmt;
        wstrb_q  <= wstrb_fmt;
        we_q     <= mem_write_c_i;
        funct3_q <= mem_funct3_i;
        offset_q <= offset_eff;
      end
      if (state_q == WAIT && bus_rvalid_i) load_data_q <= load_fmt;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= accept && trap;
      if (accept && trap && !mem_write_c_i) load_data_q <= '0;
`endif
    end
  end

  assign stall_c_o   = accept || (state_q == REQ) || (state_q == WAIT);
  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_wstrb_o = wstrb_q;
  assign load_data_o = load_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases plus randomized loads/stores
// against a byte-addressed reference memory kept in the bench.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, load_data;
  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_load;
  logic [7:0]  ref_mem [0:63];

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_c_i   (mem_req),
    .mem_write_c_i (mem_write),
    .mem_funct3_i  (funct3),
    .addr_i        (addr),
    .store_data_i  (store_data),
    .load_data_o   (load_data),
    .stall_c_o     (stall),
    .bus_req_o     (bus_req),
    .bus_we_o      (bus_we),
    .bus_addr_o    (bus_addr),
    .bus_wdata_o   (bus_wdata),
    .bus_wstrb_o   (bus_wstrb),
    .bus_gnt_i     (bus_gnt),
    .bus_rvalid_i  (bus_rvalid),
    .bus_rdata_i   (bus_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign)
`endif
  );

  // ---------------- reference model (plain arithmetic on bytes) ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_eff(input logic [2:0] f3, input logic [31:0] a);
    return a - (a % m_size(f3));
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int sz = m_size(f3);
    int base = m_eff(f3, a) % 4;
    return 4'(((1 << sz) - 1) << base);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (m_size(f3) == 1) return (d & 32'hFF) * 32'h01010101;
    if (m_size(f3) == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b = int'((a - 32'h200) & 32'h3C);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int sz = m_size(f3);
    int b = int'(m_eff(f3, a) - 32'h200);
    logic [31:0] v = 0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[b+i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 1);
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int b = int'(m_eff(f3, a) - 32'h200);
    for (int i = 0; i < m_size(f3); i++) ref_mem[b+i] = 8'(d >> (8 * i));
  endtask

  // ---------------- one complete access, checked every cycle ----------------
  task automatic do_access(input string name, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rword,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_wstrb, input logic [31:0] exp_load);
    int stall_cnt = 0;
    int exp_stall = 2 + gnt_dly + (w ? 0 : rv_dly + 1);
    mem_req = 1'b1; mem_write = w; funct3 = f3; addr = a; store_data = d;
    #1;
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    addr = $urandom; store_data = $urandom;
    for (int k = 0; k <= gnt_dly; k++) begin
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== exp_addr || bus_we !== w || bus_wstrb !== exp_wstrb ||
          (w && bus_wdata !== exp_wdata)) begin
        errors++;
        $display("FAIL %s req cycle %0d: req=%b we=%b addr=%h wdata=%h wstrb=%b, want req=1 we=%b addr=%h wdata=%h wstrb=%b",
                 name, k, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, w, exp_addr, exp_wdata, exp_wstrb);
      end
      bus_gnt = (k == gnt_dly);
      if (stall) stall_cnt++;
      @(posedge clk); #1;
    end
    bus_gnt = 1'b0;
    if (!w) begin
      for (int k = 0; k <= rv_dly; k++) begin
        checks++;
        if (bus_req !== 1'b0) begin
          errors++;
          $display("FAIL %s wait cycle %0d: bus_req=%b, want 0", name, k, bus_req);
        end
        bus_rvalid = (k == rv_dly);
        bus_rdata  = (k == rv_dly) ? rword : $urandom;
        if (stall) stall_cnt++;
        @(posedge clk); #1;
      end
      bus_rvalid = 1'b0;
      last_load  = exp_load;
    end
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0 || load_data !== last_load) begin
      errors++;
      $display("FAIL %s done: stall=%b req=%b load_data=%h, want stall=0 req=0 load_data=%h",
               name, stall, bus_req, load_data, last_load);
    end
    checks++;
    if (stall_cnt != exp_stall) begin
      errors++;
      $display("FAIL %s stall cycles: got %0d, want %0d", name, stall_cnt, exp_stall);
    end
    @(posedge clk); #1;
  endtask

  // mem_req stays high through DONE; the unit must be idle afterwards, not restarted.
  task automatic idle_gap(input string name);
    mem_req = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL %s idle after done: stall=%b req=%b, want 0 0", name, stall, bus_req);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; mem_req = 1'b0; mem_write = 1'b0; funct3 = 3'b0; addr = '0; store_data = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; last_load = '0;
    #2;
    checks++;
    if (bus_req !== 0 || bus_we !== 0 || bus_addr !== 0 || bus_wdata !== 0 || bus_wstrb !== 0 ||
        load_data !== 0 || stall !== 0) begin
      errors++;
      $display("FAIL reset outputs: req=%b we=%b addr=%h wdata=%h wstrb=%b ld=%h stall=%b, want all 0",
               bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, load_data, stall);
    end
    mem_req = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset stall follows req: stall=%b, want 1", stall);
    end
    mem_req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    do_access("sw_0x100", 1'b1, SW, 32'h100, 32'hDEADBEEF, 0, 0, '0,
              32'h100, 32'hDEADBEEF, 4'b1111, '0);
    idle_gap("sw_0x100");
    do_access("sb_0x103", 1'b1, SB, 32'h103, 32'h000000A5, 1, 0, '0,
              32'h100, 32'hA5A5A5A5, 4'b1000, '0);
    idle_gap("sb_0x103");
  endtask

  task automatic test_load();
    do_access("lb_0x102", 1'b0, LB, 32'h102, '0, 0, 0, 32'h12F03456,
              32'h100, '0, 4'b0000, 32'hFFFFFFF0);
    idle_gap("lb_0x102");
    do_access("lbu_0x102", 1'b0, LBU, 32'h102, '0, 0, 0, 32'h12F03456,
              32'h100, '0, 4'b0000, 32'h000000F0);
    idle_gap("lbu_0x102");
    do_access("lh_slow", 1'b0, LH, 32'h102, '0, 3, 1, 32'h80017FFF,
              32'h100, '0, 4'b0000, 32'hFFFF8001);
    idle_gap("lh_slow");
    // A store must leave the last load result untouched.
    do_access("sh_keep", 1'b1, SH, 32'h10A, 32'h0000BEEF, 0, 0, '0,
              32'h108, 32'hBEEFBEEF, 4'b1100, '0);
    idle_gap("sh_keep");
  endtask

  task automatic test_back_to_back();
    do_access("b2b_sw", 1'b1, SW, 32'h140, 32'h11223344, 0, 0, '0,
              32'h140, 32'h11223344, 4'b1111, '0);
    do_access("b2b_lhu", 1'b0, LHU, 32'h146, '0, 0, 0, 32'h9ABC5566,
              32'h144, '0, 4'b0000, 32'h00009ABC);
    do_access("b2b_lw", 1'b0, LW, 32'h148, '0, 1, 2, 32'h0BADF00D,
              32'h148, '0, 4'b0000, 32'h0BADF00D);
    idle_gap("b2b_lw");
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    mem_req = 1'b1; mem_write = 1'b0; funct3 = LW; addr = 32'h101;
    #1;
    checks++;
    if (stall !== 1'b1 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL misalign idle: stall=%b req=%b, want 1 0", stall, bus_req);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_req !== 1'b0 || misalign !== 1'b1 || stall !== 1'b0 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL misalign done: req=%b mis=%b stall=%b ld=%h, want 0 1 0 0",
               bus_req, misalign, stall, load_data);
    end
    last_load = '0;
    mem_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (misalign !== 1'b0 || bus_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL misalign pulse end: mis=%b req=%b stall=%b, want 0 0 0", misalign, bus_req, stall);
    end
`else
    do_access("lw_0x101", 1'b0, LW, 32'h101, '0, 0, 0, 32'hCAFEF00D,
              32'h100, '0, 4'b0000, 32'hCAFEF00D);
    idle_gap("lw_0x101");
    do_access("lh_0x103", 1'b0, LH, 32'h103, '0, 0, 0, 32'h89AB1234,
              32'h100, '0, 4'b0000, 32'hFFFF89AB);
    idle_gap("lh_0x103");
    do_access("sh_0x103", 1'b1, SH, 32'h103, 32'h1234ABCD, 0, 0, '0,
              32'h100, 32'hABCDABCD, 4'b1100, '0);
    idle_gap("sh_0x103");
`endif
  endtask

  task automatic test_random();
    logic [2:0]  ld_f3 [5];
    logic [2:0]  f3;
    logic [31:0] a, d, rw;
    logic        w;
    ld_f3 = '{LB, LH, LW, LBU, LHU};
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'($urandom);
    for (int n = 0; n < 40; n++) begin
      w  = 1'($urandom % 2);
      f3 = w ? 3'($urandom % 3) : ld_f3[$urandom % 5];
      a  = 32'h200 + (($urandom % 64) & ~(m_size(f3) - 1));
      d  = $urandom;
      if (w) begin
        do_access("rnd_store", 1'b1, f3, a, d, $urandom % 3, 0, '0,
                  a & ~32'h3, m_wdata(f3, d), m_wstrb(f3, a), '0);
        ref_store(f3, a, d);
      end else begin
        rw = ref_word(a);
        do_access("rnd_load", 1'b0, f3, a, '0, $urandom % 3, $urandom % 3, rw,
                  a & ~32'h3, '0, 4'b0000, ref_load(f3, a));
      end
      if ($urandom % 2 == 0) idle_gap("rnd");
    end
    idle_gap("rnd_end");
  endtask

  task automatic test_reset_mid_access();
    mem_req = 1'b1; mem_write = 1'b0; funct3 = LW; addr = 32'h104;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    checks++;
    if (stall !== 1'b1 || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait setup: stall=%b req=%b, want 1 0", stall, bus_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_req !== 0 || bus_we !== 0 || bus_addr !== 0 || bus_wdata !== 0 || bus_wstrb !== 0 ||
        load_data !== 0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait immediate: req=%b we=%b addr=%h wstrb=%b ld=%h stall=%b, want 0 0 0 0 0 1",
               bus_req, bus_we, bus_addr, bus_wstrb, load_data, stall);
    end
    mem_req = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait stall: stall=%b, want 0", stall);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    checks++;
    if (load_data !== 32'h0 || bus_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_late_rvalid: ld=%h req=%b stall=%b, want 0 0 0", load_data, bus_req, stall);
    end
    last_load = '0;
    do_access("post_rst_lb", 1'b0, LB, 32'h201, '0, 0, 0, 32'h00007F00,
              32'h200, '0, 4'b0000, 32'h0000007F);
    idle_gap("post_rst_lb");
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_misalign();
    test_random();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
